logic_sweep_ctrl: RTL and testbench

//  Self-test sequencer for the 3-input combinational LOGIC block.
//  On start, drives every input vector 0..2^N_IN-1 onto the LOGIC inputs and waits SETTLE_CYC cycles per vector.

---
 rtl/logic_sweep_ctrl_pkg.sv | 8 +
 rtl/logic_sweep_ctrl_settle_timer.sv | 25 ++
 rtl/logic_sweep_ctrl.sv | 108 ++++++++++
 tb/tb_logic_sweep_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/logic_sweep_ctrl_pkg.sv
// logic_sweep_defs: shared FSM state encodings and default expected truth table
package logic_sweep_defs;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [7:0] EXPECT_DEFAULT = 8'hE8;
endpackage

// File: rtl/logic_sweep_ctrl_settle_timer.sv
// settle_timer: loadable down-counter timing how long each vector is held
//   clk, rst   clock, synchronous active-high reset
//   load       reload the count with SETTLE_CYC
//   dec        decrement the count this cycle
//   zero_next  count reaches zero on this decrement
module settle_timer #(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero_next
);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load ? CW'(SETTLE_CYC) : dec ? cnt_q - CW'(1) : cnt_q;
    zero_next = dec && cnt_q == CW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/logic_sweep_ctrl.sv
// logic_sweep_ctrl: sweeps all input vectors of a LOGIC block, captures its truth table, compares to EXPECT
//   start/abort      begin / cancel a sweep
//   dut_in, dut_out  vector driven to LOGIC and its output
//   busy, done       sweep in progress / one-cycle end pulse
//   pass, table_out  match result and captured table
//   fail_idx         lowest mismatching index (valid when done && !pass)
//   LOGIC_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatch
module logic_sweep_ctrl
  import logic_sweep_defs::*;
#(
  parameter int N_IN = 3,
  parameter int SETTLE_CYC = 2,
  parameter logic [2**N_IN-1:0] EXPECT = EXPECT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   dut_in,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [2**N_IN-1:0] table_out,
  output logic [N_IN-1:0]   fail_idx
);
  localparam int TW = 2**N_IN;
  logic [1:0] state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d, fidx_q, fidx_d;
  logic [TW-1:0] tbl_q, tbl_d;
  logic pass_q, pass_d, mis_q, mis_d;
  logic load, dec, zero_next, bad, stop;
  settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .clk(clk), .rst(rst), .load(load), .dec(dec), .zero_next(zero_next)
  );
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    tbl_d = tbl_q;
    pass_d = pass_q;
    fidx_d = fidx_q;
    mis_d = mis_q;
    load = 1'b0;
    dec = 1'b0;
    bad = dut_out != EXPECT[vec_q];
`ifdef LOGIC_SWEEP_STOP_ON_FAIL_EN
    stop = bad || &vec_q;
`else
    stop = &vec_q;
`endif
    case (state_q)
      S_IDLE: if (start && !abort) begin
        state_d = S_SETTLE;
        vec_d = '0;
        tbl_d = '0;
        pass_d = 1'b0;
        fidx_d = '0;
        mis_d = 1'b0;
        load = 1'b1;
      end
      S_SETTLE: begin
        dec = 1'b1;
        state_d = zero_next ? S_SAMPLE : S_SETTLE;
      end
      S_SAMPLE: begin
        tbl_d[vec_q] = dut_out;
        fidx_d = bad && !mis_q ? vec_q : fidx_q;
        mis_d = mis_q || bad;
        state_d = stop ? S_DONE : S_SETTLE;
        pass_d = stop ? !(mis_q || bad) : pass_q;
        vec_d = stop ? '0 : vec_q + N_IN'(1);
        load = !stop;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      vec_d = '0;
      pass_d = 1'b0;
      load = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q <= '0;
      tbl_q <= '0;
      pass_q <= 1'b0;
      fidx_q <= '0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      tbl_q <= tbl_d;
      pass_q <= pass_d;
      fidx_q <= fidx_d;
      mis_q <= mis_d;
    end
  end
  always_comb begin
    dut_in = vec_q;
    busy = state_q == S_SETTLE || state_q == S_SAMPLE;
    done = state_q == S_DONE;
    pass = pass_q;
    table_out = tbl_q;
    fail_idx = fidx_q;
  end
endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// tb_logic_sweep_ctrl: randomized truth-table sweeps checked against a behavioural reference
module tb_logic_sweep_ctrl;
  localparam int SC = 2;
  localparam logic [7:0] EXP = 8'hE8;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] model = EXP;
  logic [2:0] dut_in, fail_idx;
  logic dut_out, busy, done, pass;
  logic [7:0] table_out;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign dut_out = model[dut_in];
  logic_sweep_ctrl #(.N_IN(3), .SETTLE_CYC(SC), .EXPECT(EXP)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .table_out(table_out), .fail_idx(fail_idx)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int first_bad(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i] !== EXP[i]) return i;
    return -1;
  endfunction
  task automatic run_sweep(input logic [7:0] m, input int ev_cycle, input int ev_kind);
    int fb, exp_dc, dc;
    logic [7:0] exp_tbl;
    bit seq_ok;
    fb = first_bad(m);
`ifdef LOGIC_SWEEP_STOP_ON_FAIL_EN
    exp_dc = fb < 0 ? 1 + 8 * (SC + 1) : 1 + (fb + 1) * (SC + 1);
    exp_tbl = fb < 0 ? m : m & 8'((16'd2 << fb) - 16'd1);
`else
    exp_dc = 1 + 8 * (SC + 1);
    exp_tbl = m;
`endif
    model = m;
    start = 1'b1;
    step();
    start = 1'b0;
    dc = -1;
    seq_ok = 1'b1;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start got=%b want=1", busy); end
    for (int c = 1; c < 80; c++) begin
      if (done === 1'b1) begin dc = c; break; end
      if (dut_in !== 3'((c - 1) / (SC + 1)) || busy !== 1'b1) seq_ok = 1'b0;
      if (c == ev_cycle) begin
        start = ev_kind == 1;
        abort = ev_kind == 2;
        rst = ev_kind == 3;
      end
      step();
      start = 1'b0;
      abort = 1'b0;
      rst = 1'b0;
      if (ev_kind >= 2 && c == ev_cycle) begin
        total++;
        if (busy !== 1'b0 || dut_in !== 3'd0 || done !== 1'b0 || pass !== 1'b0) begin
          bad++;
          $display("FAIL cancel_state kind=%0d got busy=%b dut_in=%0d done=%b pass=%b want 0 0 0 0", ev_kind, busy, dut_in, done, pass);
        end
        if (ev_kind == 3) begin
          total++;
          if (table_out !== 8'h00 || fail_idx !== 3'd0) begin
            bad++;
            $display("FAIL rst_clears got table=%h fail_idx=%0d want 00 0", table_out, fail_idx);
          end
        end
        for (int k = 0; k < 40; k++) begin
          if (done === 1'b1) dc = c + 1 + k;
          step();
        end
        total++;
        if (dc != -1) begin bad++; $display("FAIL no_done_after_cancel got done at %0d want none", dc); end
        return;
      end
    end
    total++;
    if (!seq_ok) begin bad++; $display("FAIL vector_sequence m=%h got mismatch want dut_in=(c-1)/%0d busy=1", m, SC + 1); end
    total++;
    if (dc != exp_dc) begin bad++; $display("FAIL done_cycle m=%h got=%0d want=%0d", m, dc, exp_dc); end
    total++;
    if (busy !== 1'b0 || dut_in !== 3'd0) begin bad++; $display("FAIL done_outputs got busy=%b dut_in=%0d want 0 0", busy, dut_in); end
    total++;
    if (table_out !== exp_tbl) begin bad++; $display("FAIL table m=%h got=%h want=%h", m, table_out, exp_tbl); end
    total++;
    if (pass !== (fb < 0)) begin bad++; $display("FAIL pass m=%h got=%b want=%b", m, pass, fb < 0); end
    total++;
    if (fail_idx !== 3'(fb < 0 ? 0 : fb)) begin bad++; $display("FAIL fail_idx m=%h got=%0d want=%0d", m, fail_idx, fb < 0 ? 0 : fb); end
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== (fb < 0) || table_out !== exp_tbl) begin
      bad++;
      $display("FAIL after_done got done=%b busy=%b pass=%b table=%h want 0 0 %b %h", done, busy, pass, table_out, fb < 0, exp_tbl);
    end
    step();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    total++;
    if (dut_in !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || table_out !== 8'h00 || fail_idx !== 3'd0) begin
      bad++;
      $display("FAIL reset got dut_in=%0d busy=%b done=%b pass=%b table=%h fail_idx=%0d want all 0", dut_in, busy, done, pass, table_out, fail_idx);
    end
  endtask
  task automatic test_majority();
    run_sweep(EXP, 0, 0);
  endtask
  task automatic test_fail5();
    run_sweep(EXP ^ 8'h20, 0, 0);
    run_sweep(EXP ^ 8'h01, 0, 0);
    run_sweep(EXP ^ 8'h80, 0, 0);
  endtask
  task automatic test_random();
    for (int i = 0; i < 6; i++) run_sweep(8'($urandom), 0, 0);
  endtask
  task automatic test_abort();
    run_sweep(EXP, 10, 2);
    run_sweep(EXP, 0, 0);
  endtask
  task automatic test_restart_ignored();
    run_sweep(EXP, 5, 1);
  endtask
  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || dut_in !== 3'd0) begin bad++; $display("FAIL start_abort_idle got busy=%b dut_in=%0d want 0 0", busy, dut_in); end
    repeat (30) step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL start_abort_idle_later got busy=%b done=%b want 0 0", busy, done); end
  endtask
  task automatic test_rst_mid();
    run_sweep(8'($urandom), 12, 3);
    run_sweep(EXP, 0, 0);
  endtask
  initial begin
    test_reset();
    test_majority();
    test_fail5();
    test_random();
    test_abort();
    test_restart_ignored();
    test_start_abort_idle();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
